// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for a shared-ALU / shared-memory MIPS-subset datapath.
// State register, next-state logic and output decode are kept as three separate processes.
module multicycle_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_ADDI  = 6'h08,
    parameter logic [5:0] OP_SLTI  = 6'h0A,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic [1:0] pc_src_o,
    output logic       ir_write_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       mem_to_reg_o,
    output logic       reg_dst_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic [3:0] state_o,
    output logic       instr_done_o,
    output logic       illegal_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10
    } state_e;

    state_e state_q;
    state_e state_d;

    // State register with synchronous reset to FETCH.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; unused encodings fall back to FETCH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode_i)
                    OP_RTYPE:        state_d = S_EXEC_R;
                    OP_LW, OP_SW:    state_d = S_MEM_ADDR;
                    OP_ADDI, OP_SLTI: state_d = S_EXEC_I;
                    OP_BEQ:          state_d = S_BRANCH;
                    default:         state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode_i == OP_LW) begin
                    state_d = S_MEM_RD;
                end else if (opcode_i == OP_SW) begin
                    state_d = S_MEM_WR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM_RD:   state_d = mem_ready_i ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   state_d = mem_ready_i ? S_FETCH : S_MEM_WR;
            S_EXEC_R:   state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_EXEC_I:   state_d = S_I_WB;
            S_I_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Output decode; reset forces every output, including Mealy terms, to zero.
    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        pc_src_o        = 2'b00;
        ir_write_o      = 1'b0;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_dst_o       = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = 2'b00;
        alu_op_o        = 3'b000;
        state_o         = 4'd0;
        instr_done_o    = 1'b0;
        illegal_o       = 1'b0;
        if (!rst_i) begin
            state_o = state_q;
            case (state_q)
                S_FETCH: begin
                    mem_read_o  = 1'b1;
                    alu_src_b_o = 2'b01;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                end
                S_DECODE: begin
                    alu_src_b_o = 2'b11;
                    case (opcode_i)
                        OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_SLTI, OP_BEQ: illegal_o = 1'b0;
                        default: begin
                            illegal_o    = 1'b1;
                            instr_done_o = 1'b1;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                end
                S_MEM_RD: begin
                    iord_o     = 1'b1;
                    mem_read_o = 1'b1;
                end
                S_MEM_WB: begin
                    mem_to_reg_o = 1'b1;
                    reg_write_o  = 1'b1;
                    instr_done_o = 1'b1;
                end
                S_MEM_WR: begin
                    iord_o       = 1'b1;
                    mem_write_o  = 1'b1;
                    instr_done_o = mem_ready_i;
                end
                S_EXEC_R: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = 3'b010;
                end
                S_R_WB: begin
                    reg_dst_o    = 1'b1;
                    reg_write_o  = 1'b1;
                    instr_done_o = 1'b1;
                end
                S_EXEC_I: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'b10;
                    alu_op_o    = (opcode_i == OP_SLTI) ? 3'b111 : 3'b011;
                end
                S_I_WB: begin
                    reg_write_o  = 1'b1;
                    instr_done_o = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a_o     = 1'b1;
                    alu_op_o        = 3'b001;
                    pc_write_cond_o = 1'b1;
                    pc_src_o        = 2'b01;
                    instr_done_o    = 1'b1;
                end
                default: state_o = state_q;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, then random instruction streams whose
// expected per-cycle outputs are expanded from each instruction's cycle recipe.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       pcwc;
        logic [1:0] pcsrc;
        logic       irw;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       m2r;
        logic       rdst;
        logic       rw;
        logic       asa;
        logic [1:0] asb;
        logic [2:0] aop;
        logic       done;
        logic       ill;
    } out_t;

    typedef struct packed {
        logic       rst;
        logic [5:0] op;
        logic       rdy;
        out_t       exp;
    } vec_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [5:0] opcode_i = 6'h00;
    logic       mem_ready_i = 1'b0;
    logic       pc_write_o, pc_write_cond_o, ir_write_o, iord_o, mem_read_o, mem_write_o;
    logic       mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, instr_done_o, illegal_o;
    logic [1:0] pc_src_o, alu_src_b_o;
    logic [2:0] alu_op_o;
    logic [3:0] state_o;
    out_t       got_s;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];
    vec_t ins[$];

    multicycle_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
        .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .pc_src_o(pc_src_o),
        .ir_write_o(ir_write_o), .iord_o(iord_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o), .reg_dst_o(reg_dst_o),
        .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .alu_op_o(alu_op_o), .state_o(state_o), .instr_done_o(instr_done_o),
        .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    assign got_s = {state_o, pc_write_o, pc_write_cond_o, pc_src_o, ir_write_o, iord_o,
                    mem_read_o, mem_write_o, mem_to_reg_o, reg_dst_o, reg_write_o,
                    alu_src_a_o, alu_src_b_o, alu_op_o, instr_done_o, illegal_o};

    function automatic logic is_legal(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h08) || (op == 6'h0A) ||
               (op == 6'h23) || (op == 6'h2B) || (op == 6'h04);
    endfunction

    function automatic out_t fetch_o(input logic rdy);
        out_t o = '0;
        o.mr  = 1'b1;
        o.asb = 2'b01;
        o.irw = rdy;
        o.pcw = rdy;
        return o;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expand one instruction into its expected cycle list, given wait counts for FETCH and memory.
    task automatic build_instr(input logic [5:0] op, input int fw, input int mw);
        out_t o;
        ins.delete();
        for (int i = 0; i < fw; i++) ins.push_back('{1'b0, op, 1'b0, fetch_o(1'b0)});
        ins.push_back('{1'b0, op, 1'b1, fetch_o(1'b1)});
        o = '0; o.st = 4'd1; o.asb = 2'b11;
        if (!is_legal(op)) begin
            o.ill = 1'b1; o.done = 1'b1;
            ins.push_back('{1'b0, op, rbit(), o});
            return;
        end
        ins.push_back('{1'b0, op, rbit(), o});
        if (op == 6'h04) begin
            o = '0; o.st = 4'd10; o.asa = 1'b1; o.aop = 3'b001; o.pcwc = 1'b1;
            o.pcsrc = 2'b01; o.done = 1'b1;
            ins.push_back('{1'b0, op, rbit(), o});
        end else if (op == 6'h00) begin
            o = '0; o.st = 4'd6; o.asa = 1'b1; o.aop = 3'b010;
            ins.push_back('{1'b0, op, rbit(), o});
            o = '0; o.st = 4'd7; o.rdst = 1'b1; o.rw = 1'b1; o.done = 1'b1;
            ins.push_back('{1'b0, op, rbit(), o});
        end else if (op == 6'h08 || op == 6'h0A) begin
            o = '0; o.st = 4'd8; o.asa = 1'b1; o.asb = 2'b10;
            o.aop = (op == 6'h0A) ? 3'b111 : 3'b011;
            ins.push_back('{1'b0, op, rbit(), o});
            o = '0; o.st = 4'd9; o.rw = 1'b1; o.done = 1'b1;
            ins.push_back('{1'b0, op, rbit(), o});
        end else begin
            o = '0; o.st = 4'd2; o.asa = 1'b1; o.asb = 2'b10;
            ins.push_back('{1'b0, op, rbit(), o});
            o = '0; o.iord = 1'b1;
            if (op == 6'h23) begin
                o.st = 4'd3; o.mr = 1'b1;
                for (int i = 0; i <= mw; i++) ins.push_back('{1'b0, op, (i == mw), o});
                o = '0; o.st = 4'd4; o.m2r = 1'b1; o.rw = 1'b1; o.done = 1'b1;
                ins.push_back('{1'b0, op, rbit(), o});
            end else begin
                o.st = 4'd5; o.mw = 1'b1;
                for (int i = 0; i < mw; i++) ins.push_back('{1'b0, op, 1'b0, o});
                o.done = 1'b1;
                ins.push_back('{1'b0, op, 1'b1, o});
            end
        end
    endtask

    task automatic append_ins();
        foreach (ins[i]) tbl.push_back(ins[i]);
    endtask

    task automatic apply(input vec_t v, input int idx);
        rst_i       = v.rst;
        opcode_i    = v.op;
        mem_ready_i = v.rdy;
        #2;
        checks++;
        if (got_s !== v.exp) begin
            errors++;
            $display("FAIL step%0d op=%h rst=%b rdy=%b: outputs got %h expected %h (state got %0d exp %0d)",
                     idx, v.op, v.rst, v.rdy, got_s, v.exp, got_s.st, v.exp.st);
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        out_t o;
        logic [5:0] ops [6] = '{6'h00, 6'h08, 6'h0A, 6'h23, 6'h2B, 6'h04};
        logic [5:0] op;
        int cut;

        // Reset, then R-type with ready always high.
        tbl.push_back('{1'b1, 6'h00, 1'b1, out_t'('0)});
        tbl.push_back('{1'b1, 6'h00, 1'b1, out_t'('0)});
        tbl.push_back('{1'b0, 6'h00, 1'b1, fetch_o(1'b1)});
        o = '0; o.st = 4'd1; o.asb = 2'b11;
        tbl.push_back('{1'b0, 6'h00, 1'b1, o});
        o = '0; o.st = 4'd6; o.asa = 1'b1; o.aop = 3'b010;
        tbl.push_back('{1'b0, 6'h00, 1'b1, o});
        o = '0; o.st = 4'd7; o.rdst = 1'b1; o.rw = 1'b1; o.done = 1'b1;
        tbl.push_back('{1'b0, 6'h00, 1'b1, o});

        // lw with waits, sw, beq, slti, illegal.
        build_instr(6'h23, 2, 3); append_ins();
        build_instr(6'h2B, 0, 0); append_ins();
        build_instr(6'h04, 0, 0); append_ins();
        build_instr(6'h0A, 0, 0); append_ins();
        build_instr(6'h3F, 0, 0); append_ins();

        // Reset while MEM_WR waits, then addi.
        build_instr(6'h2B, 0, 2);
        for (int i = 0; i < 4; i++) tbl.push_back(ins[i]);
        tbl.push_back('{1'b1, 6'h2B, 1'b0, out_t'('0)});
        tbl.push_back('{1'b0, 6'h08, 1'b0, fetch_o(1'b0)});
        build_instr(6'h08, 0, 0); append_ins();

        // Random instruction stream, with occasional reset at an arbitrary cycle.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) < 6) op = ops[$urandom_range(0, 5)];
            else op = 6'($urandom_range(0, 63));
            build_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                cut = $urandom_range(0, ins.size() - 1);
                for (int i = 0; i < cut; i++) tbl.push_back(ins[i]);
                tbl.push_back('{1'b1, ins[cut].op, rbit(), out_t'('0)});
            end else begin
                append_ins();
            end
        end

        #1;
        foreach (tbl[i]) apply(tbl[i], i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Control state machine that sequences a shared-ALU, shared-memory MIPS-subset datapath over multiple cycles. It replaces per-instruction combinational decode with a Moore/Mealy FSM. Each instruction is fetched, decoded and executed across 3–5 cycles. Memory accesses stall on a ready handshake. The block sits between the instruction register / memory interface and the datapath muxes, register file, ALU control and PC.

## Interface
Parameters:
- OP_RTYPE, 6'h00 — R-type opcode
- OP_ADDI, 6'h08 — addi opcode
- OP_SLTI, 6'h0A — slti opcode
- OP_LW, 6'h23 — load word opcode
- OP_SW, 6'h2B — store word opcode
- OP_BEQ, 6'h04 — branch-equal opcode

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset; synchronous, active-high
- opcode_i  in  6  instr[31:26] from the instruction register; stable from DECODE onward
- mem_ready_i  in  1  memory completes the current read/write this cycle
- pc_write_o  out  1  unconditional PC load
- pc_write_cond_o  out  1  PC load if ALU zero (beq)
- pc_src_o  out  2  00 ALU result, 01 ALUOut register
- ir_write_o  out  1  latch instruction register
- iord_o  out  1  memory address select: 0 PC, 1 ALUOut
- mem_read_o, mem_write_o  out  1 each  memory strobes
- mem_to_reg_o  out  1  register write data select: 1 MDR, 0 ALUOut
- reg_dst_o  out  1  write-register select: 1 rd, 0 rt
- reg_write_o  out  1  register file write enable
- alu_src_a_o  out  1  0 PC, 1 register A
- alu_src_b_o  out  2  00 register B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_op_o  out  3  000 add, 001 sub, 010 R-type (funct decides), 011 addi, 111 slti
- state_o  out  4  current state encoding (debug)
- instr_done_o  out  1  one-cycle pulse in the final cycle of each instruction
- illegal_o  out  1  one-cycle pulse when DECODE sees an unsupported opcode

## Operation
States and encodings:
- FETCH = 0
- DECODE = 1
- MEM_ADDR = 2
- MEM_RD = 3
- MEM_WB = 4
- MEM_WR = 5
- EXEC_R = 6
- R_WB = 7
- EXEC_I = 8
- I_WB = 9
- BRANCH = 10

Outputs not listed for a state are 0.
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=00.
  - While mem_ready_i=1: ir_write=1 and pc_write=1, and the FSM goes to DECODE. These two outputs are Mealy on mem_ready_i.
  - Otherwise the FSM stays in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut).
  - Next state by opcode_i: R-type → EXEC_R; lw/sw → MEM_ADDR; addi/slti → EXEC_I; beq → BRANCH.
  - Any other opcode: illegal=1, instr_done=1, next state FETCH. The instruction acts as a NOP; the PC has already advanced.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000. Goes to MEM_RD for lw, MEM_WR for sw. The opcode is re-read; opcode_i is held stable.
- MEM_RD: iord=1, mem_read=1. Stays until mem_ready_i; then goes to MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1. Next state FETCH.
- MEM_WR: iord=1, mem_write=1. On mem_ready_i: instr_done=1 and next state FETCH; otherwise stay.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=010. Next state R_WB.
- R_WB: reg_dst=1, mem_to_reg=0, reg_write=1, instr_done=1. Next state FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=011 (addi) or 111 (slti). Next state I_WB.
- I_WB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_src=01, instr_done=1. Next state FETCH.
- Unused encodings 11–15: all outputs 0, next state FETCH.

## Timing
- Reset:
  - rst_i is sampled on clk_i; the state becomes FETCH on the next edge.
  - While rst_i=1, every output is forced to 0, including state_o, pulses and Mealy terms.
  - Reset overrides any state, including a pending memory wait. An in-flight access is abandoned with no write strobe after the reset edge.
- Cycle counts with mem_ready_i=1 on first request:
  - beq 3
  - R-type / addi / slti / sw 4
  - lw 5
  - illegal opcode 2
- Each cycle mem_ready_i stays low in FETCH, MEM_RD or MEM_WR adds one cycle.
- Strobe behaviour during a wait:
  - mem_read_o / mem_write_o stay high for every cycle of a wait.
  - ir_write_o / pc_write_o fire exactly once, in the ready cycle.
- mem_ready_i is ignored in every state except FETCH, MEM_RD and MEM_WR.
- reg_write_o and mem_write_o are never high in the same cycle.
- At most one PC-load source is high per cycle.
- instr_done_o is never high two cycles in a row.

## Test plan
- Reset then R-type (opcode 00), ready always 1:
  - state_o sequence 0,1,6,7,0.
  - reg_write=1 and reg_dst=1 only in cycle 4.
  - instr_done pulses in cycle 4.
- lw (23) with mem_ready_i low for 2 cycles in FETCH and 3 in MEM_RD:
  - Total 10 cycles.
  - ir_write and pc_write each high for exactly 1 cycle.
  - MEM_WB asserts mem_to_reg=1 and reg_write=1.
- sw (2B), ready=1:
  - States 0,1,2,5.
  - mem_write=1 with iord=1 for 1 cycle; reg_write never 1.
- beq (04) then slti (0A):
  - beq: states 0,1,10 with pc_write_cond=1, pc_src=01, alu_op=001.
  - slti: EXEC_I shows alu_op=111 and alu_src_b=10.
- Illegal opcode 3F: states 0,1,0; illegal_o and instr_done_o pulse in DECODE.
- Reset mid-operation:
  - Assert rst_i in MEM_WR while ready=0: all outputs 0 that cycle, state 0 next cycle, no mem_write after reset.
  - Then addi (08) completes in 4 cycles with alu_op=011.
